// File: rtl/cbus_rr_arbiter_pkg.sv
// cbus_rr_arbiter_pkg: cache-bus request/response types and arbiter state encoding.
// Contents:
//   mlen_t          AXI-style burst length code (encoded value = beats - 1)
//   cbus_req_t      master -> memory request
//   cbus_resp_t     memory -> master response
//   arb_state_t     arbiter FSM state
//   CBUS_MAX_BEATS  longest legal burst
package cbus_rr_arbiter_pkg;
  localparam int CBUS_MAX_BEATS = 256;
  localparam int LEN_W = $clog2(CBUS_MAX_BEATS);
  localparam int BEAT_W = LEN_W + 1;
  typedef enum logic [LEN_W-1:0] {
    MLEN1   = 8'd0,
    MLEN2   = 8'd1,
    MLEN4   = 8'd3,
    MLEN8   = 8'd7,
    MLEN16  = 8'd15,
    MLEN32  = 8'd31,
    MLEN64  = 8'd63,
    MLEN128 = 8'd127,
    MLEN256 = 8'd255
  } mlen_t;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    mlen_t       len;
    logic [63:0] data;
    logic [7:0]  strobe;
  } cbus_req_t;
  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
endpackage

// File: rtl/cbus_rr_arbiter_rr_pick.sv
// cbus_rr_arbiter_rr_pick: combinational round-robin / fixed-priority winner selection.
// Ports:
//   valid_i  request vector, one bit per requester
//   ptr_i    round-robin start index (ignored when fixed_i is high)
//   fixed_i  1 = lowest valid index wins, 0 = first valid index at or after ptr_i (wrapping)
//   idx_o    winner index (0 when nothing is valid)
//   any_o    at least one request is valid
module cbus_rr_arbiter_rr_pick
  import cbus_rr_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     valid_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  logic             fixed_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);
  localparam int CW = IDX_W + 1;
  logic [IDX_W-1:0] base;
  logic [CW-1:0]    c;
  assign base  = fixed_i ? '0 : ptr_i;
  assign any_o = |valid_i;
  // Scan offsets from farthest to nearest so the closest valid index overwrites the rest.
  always_comb begin
    idx_o = '0;
    c     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      c = {1'b0, base} + CW'(i);
      c = (c >= CW'(N)) ? c - CW'(N) : c;
      idx_o = valid_i[c[IDX_W-1:0]] ? c[IDX_W-1:0] : idx_o;
    end
  end
endmodule

// File: rtl/cbus_rr_arbiter.sv
// cbus_rr_arbiter: N-master to 1-slave cache-bus arbiter with burst-length monitor.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   ireqs         per-master requests
//   iresps        per-master responses (only the owner ever sees a non-zero response)
//   oreq          request forwarded to memory (owner's request while busy, else zero)
//   oresp         response from memory
//   grant_idx     current/last bus owner
//   busy          transaction in flight
//   len_err       one-cycle pulse after a burst ends on the wrong beat count
module cbus_rr_arbiter
  import cbus_rr_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int FIXED_PRIO = 0,
  parameter int IDX_W      = $clog2(NUM_PORTS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  cbus_req_t        ireqs [NUM_PORTS],
  output cbus_resp_t       iresps [NUM_PORTS],
  output cbus_req_t        oreq,
  input  cbus_resp_t       oresp,
  output logic [IDX_W-1:0] grant_idx,
  output logic             busy,
  output logic             len_err
);
  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d, ptr_q, ptr_d, pick_idx, grant_nxt;
  logic [BEAT_W-1:0]  beats_q, beats_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               len_err_q, len_err_d, pick_any;
  logic [NUM_PORTS-1:0] valid;
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_valid
    assign valid[g] = ireqs[g].valid;
  end
  cbus_rr_arbiter_rr_pick #(.N(NUM_PORTS), .IDX_W(IDX_W)) u_pick (
    .valid_i(valid),
    .ptr_i  (ptr_q),
    .fixed_i(FIXED_PRIO != 0),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );
  assign grant_nxt = (grant_q == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    beats_d   = beats_q;
    len_d     = len_q;
    len_err_d = 1'b0;
    oreq      = '0;
    for (int i = 0; i < NUM_PORTS; i++) iresps[i] = '0;
    if (state_q == ARB_IDLE) begin
      if (pick_any) begin
        state_d = ARB_BUSY;
        grant_d = pick_idx;
        len_d   = ireqs[pick_idx].len;
        beats_d = '0;
      end
    end else begin
      oreq            = ireqs[grant_q];
      iresps[grant_q] = oresp;
      if (oresp.ready) beats_d = (&beats_q) ? beats_q : beats_q + 1'b1;
      if (oresp.ready && oresp.last) begin
        state_d   = ARB_IDLE;
        ptr_d     = (FIXED_PRIO != 0) ? '0 : grant_nxt;
        // beats seen before the last beat must equal the encoded length (beats - 1)
        len_err_d = beats_q != {1'b0, len_q};
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      beats_q   <= '0;
      len_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      beats_q   <= beats_d;
      len_q     <= len_d;
      len_err_q <= len_err_d;
    end
  end
  assign grant_idx = grant_q;
  assign busy      = state_q == ARB_BUSY;
  assign len_err   = len_err_q;
endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// tb_cbus_rr_arbiter: directed self-checking bench for round-robin and fixed-priority arbiters.
module tb_cbus_rr_arbiter;
  import cbus_rr_arbiter_pkg::*;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  cbus_req_t  req [N];
  cbus_resp_t rsp [N];
  cbus_req_t  oreq;
  cbus_resp_t resp;
  logic [1:0] gidx;
  logic       busy, len_err;
  cbus_req_t  fp_req [N];
  cbus_resp_t fp_rsp [N];
  cbus_req_t  fp_oreq;
  cbus_resp_t fp_resp;
  logic [1:0] fp_gidx;
  logic       fp_busy, fp_len_err;
  logic [N-1:0] rdy, nz;
  int passed = 0;
  int total  = 0;
  cbus_rr_arbiter #(.NUM_PORTS(N), .FIXED_PRIO(0)) dut (
    .clk(clk), .reset_n(reset_n), .ireqs(req), .iresps(rsp), .oreq(oreq), .oresp(resp),
    .grant_idx(gidx), .busy(busy), .len_err(len_err)
  );
  cbus_rr_arbiter #(.NUM_PORTS(N), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .reset_n(reset_n), .ireqs(fp_req), .iresps(fp_rsp), .oreq(fp_oreq), .oresp(fp_resp),
    .grant_idx(fp_gidx), .busy(fp_busy), .len_err(fp_len_err)
  );
  for (genvar g = 0; g < N; g++) begin : g_mon
    assign rdy[g] = rsp[g].ready;
    assign nz[g]  = |rsp[g];
  end
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    int own, other;
    logic [1:0] exp_rr [4];
    exp_rr = '{2'd0, 2'd1, 2'd3, 2'd0};
    for (int i = 0; i < N; i++) begin
      req[i] = '0;
      fp_req[i] = '0;
    end
    resp = '0;
    fp_resp = '0;
    #12;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_gidx", 128'(gidx), 128'(0));
    chk("rst_len_err", 128'(len_err), 128'(0));
    chk("rst_oreq", 128'(oreq), 128'(0));
    chk("rst_iresps", 128'(nz), 128'(0));
    tick();
    reset_n = 1'b1;
    // single request, port 2, 16-beat read; intruder on port 0 and a mid-burst valid drop
    req[2] = '{valid: 1'b1, is_write: 1'b0, addr: 32'h1000, len: MLEN16, data: 64'h0, strobe: 8'h0};
    #1;
    chk("t1_not_yet_busy", 128'(busy), 128'(0));
    tick();
    chk("t1_gidx", 128'(gidx), 128'(2));
    chk("t1_busy", 128'(busy), 128'(1));
    chk("t1_oreq_addr", 128'(oreq.addr), 128'(32'h1000));
    req[0] = '{valid: 1'b1, is_write: 1'b0, addr: 32'h9000, len: MLEN1, data: 64'h0, strobe: 8'h0};
    own = 0;
    other = 0;
    for (int b = 1; b <= 16; b++) begin
      resp.ready = 1'b1;
      resp.last  = (b == 16);
      resp.data  = 64'(b);
      req[2].valid = (b != 8);
      #1;
      own += int'(rdy[2]);
      other += int'(rdy[0] | rdy[1] | rdy[3]);
      if (b == 8) begin
        chk("t1_drop_oreq_valid", 128'(oreq.valid), 128'(0));
        chk("t1_drop_gidx", 128'(gidx), 128'(2));
        chk("t1_drop_data", 128'(rsp[2].data), 128'(8));
      end
      tick();
    end
    resp = '0;
    req[0].valid = 1'b0;
    req[2].valid = 1'b0;
    #1;
    chk("t1_own_beats", 128'(own), 128'(16));
    chk("t1_other_ready", 128'(other), 128'(0));
    chk("t1_len_err", 128'(len_err), 128'(0));
    chk("t1_idle", 128'(busy), 128'(0));
    // length error: MLEN8 but last on beat 5
    req[0] = '{valid: 1'b1, is_write: 1'b0, addr: 32'h2000, len: MLEN8, data: 64'h0, strobe: 8'h0};
    tick();
    chk("t2_gidx", 128'(gidx), 128'(0));
    for (int b = 1; b <= 5; b++) begin
      resp.ready = 1'b1;
      resp.last  = (b == 5);
      tick();
    end
    resp = '0;
    req[0].valid = 1'b0;
    #1;
    chk("t2_len_err_pulse", 128'(len_err), 128'(1));
    chk("t2_idle", 128'(busy), 128'(0));
    tick();
    chk("t2_len_err_clear", 128'(len_err), 128'(0));
    // write passthrough, port 1
    req[1] = '{valid: 1'b1, is_write: 1'b1, addr: 32'h3000, len: MLEN1,
               data: 64'hDEADBEEF_00000000, strobe: 8'hF0};
    tick();
    chk("t3_gidx", 128'(gidx), 128'(1));
    chk("t3_is_write", 128'(oreq.is_write), 128'(1));
    chk("t3_strobe", 128'(oreq.strobe), 128'(8'hF0));
    chk("t3_data", 128'(oreq.data), 128'(64'hDEADBEEF_00000000));
    chk("t3_len", 128'(oreq.len), 128'(MLEN1));
    resp.ready = 1'b1;
    resp.last  = 1'b1;
    #1;
    chk("t3_ready_vec", 128'(rdy), 128'(4'b0010));
    tick();
    resp = '0;
    req[1].valid = 1'b0;
    #1;
    chk("t3_idle", 128'(busy), 128'(0));
    chk("t3_len_err", 128'(len_err), 128'(0));
    // reset on beat 3 of a 16-beat burst
    req[2] = '{valid: 1'b1, is_write: 1'b0, addr: 32'h4000, len: MLEN16, data: 64'h0, strobe: 8'h0};
    tick();
    chk("t4_gidx", 128'(gidx), 128'(2));
    for (int b = 1; b <= 2; b++) begin
      resp.ready = 1'b1;
      tick();
    end
    resp.ready = 1'b1;
    #1;
    chk("t4_beat3_ready", 128'(rdy), 128'(4'b0100));
    reset_n = 1'b0;
    #1;
    chk("t4_rst_busy", 128'(busy), 128'(0));
    chk("t4_rst_oreq_valid", 128'(oreq.valid), 128'(0));
    chk("t4_rst_iresps", 128'(nz), 128'(0));
    chk("t4_rst_gidx", 128'(gidx), 128'(0));
    req[2] = '0;
    resp = '0;
    tick();
    reset_n = 1'b1;
    // round-robin contention from pointer 0: ports 0, 1, 3
    for (int i = 0; i < N; i++)
      if (i != 2) req[i] = '{valid: 1'b1, is_write: 1'b0, addr: 32'(32'h5000 + i), len: MLEN1,
                             data: 64'h0, strobe: 8'h0};
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("rr_grant%0d", k), 128'(gidx), 128'(exp_rr[k]));
      chk($sformatf("rr_busy%0d", k), 128'(busy), 128'(1));
      resp.ready = 1'b1;
      resp.last  = 1'b1;
      tick();
      resp = '0;
      if (k == 3) for (int i = 0; i < N; i++) req[i].valid = 1'b0;
      #1;
      chk($sformatf("rr_bubble%0d", k), 128'(busy), 128'(0));
    end
    // fixed priority: ports 1 and 3 request continuously
    fp_req[1] = '{valid: 1'b1, is_write: 1'b0, addr: 32'h6001, len: MLEN1, data: 64'h0, strobe: 8'h0};
    fp_req[3] = '{valid: 1'b1, is_write: 1'b0, addr: 32'h6003, len: MLEN1, data: 64'h0, strobe: 8'h0};
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("fp_grant%0d", k), 128'(fp_gidx), 128'(1));
      chk($sformatf("fp_oreq_addr%0d", k), 128'(fp_oreq.addr), 128'(32'h6001));
      fp_resp.ready = 1'b1;
      fp_resp.last  = 1'b1;
      tick();
      fp_resp = '0;
    end
    fp_req[1].valid = 1'b0;
    tick();
    chk("fp_grant_low", 128'(fp_gidx), 128'(3));
    fp_resp.ready = 1'b1;
    fp_resp.last  = 1'b1;
    tick();
    fp_resp = '0;
    fp_req[3].valid = 1'b0;
    #1;
    chk("fp_idle", 128'(fp_busy), 128'(0));
    chk("fp_len_err", 128'(fp_len_err), 128'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cbus_rr_arbiter.md
Name: cbus_rr_arbiter

Overview:
- Parametrised N-master to 1-slave arbiter for the simplified burst AXI cache bus (cbus_req_t / cbus_resp_t).
- Sits between the I-cache, the D-cache, uncached bypass paths and any future masters (PTW, DMA), and the single memory port.
- Generalises a fixed 2-way arbiter in three ways: any port count, a selectable round-robin or fixed-priority mode, and a burst-length monitor that flags protocol errors.

Parameters:
- NUM_PORTS, 4, number of masters; legal range 2..16.
- FIXED_PRIO, 0, arbitration mode; 0 = round-robin, 1 = fixed priority with port 0 highest.
- IDX_W, $clog2(NUM_PORTS), width of the grant index (derived; do not override).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ireqs  in  NUM_PORTS x cbus_req_t  per-master requests.
- iresps  out  NUM_PORTS x cbus_resp_t  per-master responses.
- oreq  out  cbus_req_t  request to the memory side.
- oresp  in  cbus_resp_t  response from the memory side.
- grant_idx  out  IDX_W  index of the master currently owning the bus (debug).
- busy  out  1  high while a transaction is in flight.
- len_err  out  1  one-cycle pulse when a burst ends on the wrong beat count.

Behaviour:
- Reset values (asynchronous on reset_n low):
  - state = IDLE, grant_idx = 0, busy = 0, len_err = 0.
  - Round-robin pointer = 0, beat counter = 0.
  - oreq = all zero; every iresps entry = all zero.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - oreq = 0 and all iresps = 0.
  - If any ireqs[i].valid is high, register the winner into grant_idx.
  - Latch the winner's len into len_q and clear the beat counter.
  - Move to BUSY on the next edge, so the grant latency is 1 cycle after valid is seen.
- Winner selection:
  - FIXED_PRIO = 1: the lowest valid index wins.
  - FIXED_PRIO = 0: the first valid index at or after the pointer wins, scanning upward and wrapping modulo NUM_PORTS.
- BUSY:
  - oreq = ireqs[grant_idx] passed through combinationally.
  - iresps[grant_idx] = oresp; every other iresps entry = 0, so ready is never visible to a non-owner.
  - Each cycle with oresp.ready high increments the beat counter.
- End of transaction: oresp.ready && oresp.last in BUSY moves the FSM to IDLE on the next edge.
  - Round-robin pointer becomes (grant_idx + 1) mod NUM_PORTS; in fixed-priority mode the pointer is unused and stays 0.
  - Length check: if the beat counter plus one does not equal len_q + 1, len_err pulses high for exactly one cycle, the cycle after last.
- Ownership is held until last:
  - No preemption; requests arriving from other ports during BUSY are ignored.
  - If the owner drops valid mid-burst, the grant is still held; oreq.valid follows the owner's valid, and the owner stays granted until last.
- Back-to-back: after last, one IDLE cycle always precedes the next grant (fixed 1-cycle bubble).
- Simultaneous valid requests: exactly one grant per arbitration.
- Starvation bound (round-robin): a continuously requesting port waits at most NUM_PORTS-1 transactions.
- Write transactions: is_write, strobe and data are passed through unchanged. Each data beat is acknowledged by oresp.ready; last marks the final beat, the same as for reads.
- Reset mid-burst: the arbiter returns to IDLE immediately. The memory side must also be reset; no completion is replayed.
- Beat counter width is 9 bits (covers MLEN256 = 256 beats); saturates at 511.

Decomposition:
- Shared package gets:
  - typedef arb_state_t enum {ARB_IDLE, ARB_BUSY};
  - a constant CBUS_MAX_BEATS = 256.
- mlen_t, cbus_req_t and cbus_resp_t are reused as-is from the common package.
- One sub-module is natural: rr_pick.
  - Purely combinational.
  - Inputs: valid vector, pointer, mode.
  - Outputs: winner index and any-valid flag.
  - Reusable by future interrupt or issue arbiters.

Test Plan:
- Single request: port 2 issues a read with len = MLEN16; memory returns 16 beats with last on the 16th. Required: grant_idx = 2 one cycle after valid; iresps[2] sees 16 ready beats; other ports see ready = 0; len_err = 0.
- Contention, round-robin with 4 ports: ports 0, 1 and 3 request simultaneously and keep requesting. Required: grants occur in the order 0, 1, 3, 0; exactly one IDLE cycle between transactions.
- Contention, fixed priority (FIXED_PRIO = 1): ports 1 and 3 request continuously. Required: port 1 wins every arbitration; port 3 is never granted while port 1 requests.
- Length error: port 0 requests len = MLEN8; memory asserts last on beat 5. Required: len_err pulses for 1 cycle the cycle after last; FSM returns to IDLE.
- Reset mid-burst: assert reset_n = 0 on beat 3 of a 16-beat burst. Required: within the same cycle busy = 0, oreq.valid = 0 and all iresps are zero; after release, a new request is granted normally with the pointer at 0.
- Write passthrough: port 1 writes len = MLEN1 with strobe = 8'hF0 and data = 64'hDEADBEEF_00000000. Required: oreq carries these values unchanged; a single ready+last beat completes the transaction.
